riscv_mem: RTL

Memory-access stage of the danbone RISC-V pipeline, between execute and `riscv_wb`. It accepts one instruction at a time from execute and turns loads and stores into word-aligned data-bus requests with byte masks and lane-replicated store data. It then hands the instruction, with the full byte address or ALU result, to writeback through a one-entry output register. Load data is not returned through this block: writeback takes it directly from `data_bif_rdata`/`data_bif_rvalid`.

---
 rtl/riscv_mem.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/riscv_mem.sv
// Memory-access stage: turns loads/stores into word-aligned data-bus requests
// and passes each instruction to writeback through a one-entry output register.
module riscv_mem #(
   localparam int LD_FUNCT_W = 3,
   localparam int ST_FUNCT_W = 2
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  ex_mem_rdy,
   output logic                  ex_mem_ack,
   input  logic [LD_FUNCT_W-1:0] ex_mem_ld_funct,
   input  logic [ST_FUNCT_W-1:0] ex_mem_st_funct,
   input  logic [31:0]           ex_mem_data,
   input  logic [31:0]           ex_mem_wdata,
   input  logic [4:0]            ex_mem_rsd,
   output logic                  data_bif_req,
   output logic                  data_bif_rnw,
   output logic [31:0]           data_bif_addr,
   output logic [31:0]           data_bif_wdata,
   output logic [3:0]            data_bif_wmask,
   input  logic                  data_bif_ack,
   output logic                  mem_wb_rdy,
   input  logic                  mem_wb_ack,
   output logic [LD_FUNCT_W-1:0] mem_wb_funct,
   output logic [31:0]           mem_wb_data,
   output logic [4:0]            mem_wb_rsd,
   output logic                  mem_misalign
);

   localparam logic [LD_FUNCT_W-1:0] LD_NOP = 3'd0;
   localparam logic [LD_FUNCT_W-1:0] LB     = 3'd1;
   localparam logic [LD_FUNCT_W-1:0] LH     = 3'd2;
   localparam logic [LD_FUNCT_W-1:0] LW     = 3'd3;
   localparam logic [LD_FUNCT_W-1:0] LBU    = 3'd4;
   localparam logic [LD_FUNCT_W-1:0] LHU    = 3'd5;
   localparam logic [ST_FUNCT_W-1:0] ST_NOP = 2'd0;
   localparam logic [ST_FUNCT_W-1:0] SB     = 2'd1;
   localparam logic [ST_FUNCT_W-1:0] SH     = 2'd2;
   localparam logic [ST_FUNCT_W-1:0] SW     = 2'd3;

   typedef enum logic {IDLE, BUS} state_t;
   state_t state;

   logic                  is_ld, is_st, is_mis;
   logic [LD_FUNCT_W-1:0] pend_funct;
   logic [31:0]           pend_addr;
   logic [4:0]            pend_rsd;

   function automatic logic misaligned(input logic [LD_FUNCT_W-1:0] ld,
                                       input logic [ST_FUNCT_W-1:0] st,
                                       input logic [1:0] a);
      logic m;
      m = 1'b0;
      if (ld != LD_NOP) begin
         if ((ld == LH || ld == LHU) && a[0]) m = 1'b1;
         if (ld == LW && a != 2'b00)          m = 1'b1;
      end else begin
         if (st == SH && a[0])                m = 1'b1;
         if (st == SW && a != 2'b00)          m = 1'b1;
      end
      return m;
   endfunction

   function automatic logic [3:0] store_mask(input logic [ST_FUNCT_W-1:0] st,
                                             input logic [1:0] a);
      case (st)
         SB:      return 4'b0001 << a;
         SH:      return 4'b0011 << a;
         SW:      return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] store_data(input logic [ST_FUNCT_W-1:0] st,
                                              input logic [31:0] w);
      case (st)
         SB:      return {4{w[7:0]}};
         SH:      return {2{w[15:0]}};
         default: return w;
      endcase
   endfunction

   // A load wins over a store when both functs are set.
   assign is_ld  = (ex_mem_ld_funct != LD_NOP);
   assign is_st  = (ex_mem_st_funct != ST_NOP) && !is_ld;
   assign is_mis = misaligned(ex_mem_ld_funct, ex_mem_st_funct, ex_mem_data[1:0]);

   assign ex_mem_ack = (state == IDLE) && ex_mem_rdy && (!mem_wb_rdy || mem_wb_ack);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state          <= IDLE;
         data_bif_req   <= 1'b0;
         data_bif_rnw   <= 1'b0;
         data_bif_addr  <= '0;
         data_bif_wdata <= '0;
         data_bif_wmask <= '0;
         mem_wb_rdy     <= 1'b0;
         mem_wb_funct   <= LD_NOP;
         mem_wb_data    <= '0;
         mem_wb_rsd     <= '0;
         mem_misalign   <= 1'b0;
         pend_funct     <= LD_NOP;
         pend_addr      <= '0;
         pend_rsd       <= '0;
      end else begin
         mem_misalign <= 1'b0;
         if (mem_wb_rdy && mem_wb_ack) mem_wb_rdy <= 1'b0;

         case (state)
            IDLE: begin
               if (ex_mem_ack) begin
                  if ((is_ld || is_st) && is_mis) begin
                     mem_wb_rdy   <= 1'b1;
                     mem_wb_funct <= LD_NOP;
                     mem_wb_data  <= ex_mem_data;
                     mem_wb_rsd   <= 5'd0;
                     mem_misalign <= 1'b1;
                  end else if (is_ld || is_st) begin
                     state          <= BUS;
                     data_bif_req   <= 1'b1;
                     data_bif_rnw   <= is_ld;
                     data_bif_addr  <= {ex_mem_data[31:2], 2'b00};
                     data_bif_wdata <= is_ld ? 32'd0 : store_data(ex_mem_st_funct, ex_mem_wdata);
                     data_bif_wmask <= is_ld ? 4'b0000 : store_mask(ex_mem_st_funct, ex_mem_data[1:0]);
                     pend_funct     <= ex_mem_ld_funct;
                     pend_addr      <= ex_mem_data;
                     pend_rsd       <= is_ld ? ex_mem_rsd : 5'd0;
                  end else begin
                     mem_wb_rdy   <= 1'b1;
                     mem_wb_funct <= LD_NOP;
                     mem_wb_data  <= ex_mem_data;
                     mem_wb_rsd   <= ex_mem_rsd;
                  end
               end
            end
            BUS: begin
               // Output register is guaranteed empty here, so completion can load it unconditionally.
               if (data_bif_ack) begin
                  state        <= IDLE;
                  data_bif_req <= 1'b0;
                  mem_wb_rdy   <= 1'b1;
                  mem_wb_funct <= pend_funct;
                  mem_wb_data  <= pend_addr;
                  mem_wb_rsd   <= pend_rsd;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
